// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the square-root pipeline sequencer.
package sqrt_pkg;

    typedef enum logic [1:0] {
        INIT_A = 2'd0,
        INIT_B = 2'd1,
        IDLE   = 2'd2,
        RUN    = 2'd3
    } state_t;

    localparam int DEFAULT_STAGES = 4;
    localparam int DEFAULT_CNT_W  = 16;

    // Callers zero-extend their vector to 32 bits; pipelines deeper than 32 are not expected.
    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/sqrt_valid_chain.sv
// Valid-token shift register: one bit per stage bank, shifts on advance, cleared on flush.
module sqrt_valid_chain
    import sqrt_pkg::*;
#(
    parameter int STAGES = DEFAULT_STAGES
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        advance,
    input  logic                        clear,
    input  logic                        insert,
    output logic [STAGES-1:0]           valid_q,
    output logic [STAGES-1:0]           valid_next,
    output logic [$clog2(STAGES+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] valid_reg;

    assign valid_next[0] = clear ? 1'b0 : (advance ? insert : valid_reg[0]);

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_next
            assign valid_next[gi] = clear ? 1'b0 : (advance ? valid_reg[gi-1] : valid_reg[gi]);
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_reg <= '0;
        end else begin
            valid_reg <= valid_next;
        end
    end

    assign valid_q   = valid_reg;
    assign occupancy = OCC_W'(popcount(32'(valid_reg)));

endmodule

// File: rtl/sqrt_pipe_ctrl.sv
// Sequencer for the pipelined square-root datapath: stage enables, init strobes,
// valid tracking, input/output handshakes, stall and flush.
module sqrt_pipe_ctrl
    import sqrt_pkg::*;
#(
    parameter int STAGES = DEFAULT_STAGES,
    parameter int CNT_W  = DEFAULT_CNT_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    input  logic                        flush,
    output logic [STAGES-1:0]           stage_en,
    output logic [STAGES-1:0]           stage_init,
    output logic [$clog2(STAGES+1)-1:0] occupancy,
    output logic                        busy,
    output logic [CNT_W-1:0]            done_cnt
);

    state_t            state_reg;
    state_t            state_next;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_next;
    logic [STAGES-1:0] stage_init_reg;
    logic [CNT_W-1:0]  done_reg;
    logic              op_state;
    logic              adv;
    logic              in_xfer;
    logic              out_xfer;
    logic              chain_clear;

    // A full last stage only moves when the consumer takes it; bubbles are never squeezed out.
    assign op_state    = (state_reg == IDLE) || (state_reg == RUN);
    assign adv         = ~valid_q[STAGES-1] | out_ready;
    assign in_ready    = adv & op_state & ~flush;
    assign in_xfer     = in_valid & in_ready;
    assign out_valid   = valid_q[STAGES-1] & (state_reg == RUN);
    assign out_xfer    = out_valid & out_ready;
    assign chain_clear = op_state & flush;

    sqrt_valid_chain #(
        .STAGES (STAGES)
    ) u_chain (
        .clock      (clock),
        .reset      (reset),
        .advance    (adv),
        .clear      (chain_clear),
        .insert     (in_xfer),
        .valid_q    (valid_q),
        .valid_next (valid_next),
        .occupancy  (occupancy)
    );

    assign stage_en[0] = in_xfer;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage_en
            assign stage_en[gi] = adv & valid_q[gi-1];
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= INIT_A;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INIT_A: state_next = INIT_B;
            INIT_B: state_next = IDLE;
            IDLE: begin
                if (flush) begin
                    state_next = INIT_A;
                end else if (in_xfer) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_next = INIT_A;
                end else if (valid_next == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = INIT_A;
        endcase
    end

    // Registered so the stage banks' set/reset pins see a clean, glitch-free pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_init_reg <= '1;
        end else begin
            stage_init_reg <= {STAGES{state_next == INIT_A}};
        end
    end

    // Result count survives flush; only reset clears it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_reg <= '0;
        end else if (out_xfer) begin
            done_reg <= done_reg + 1'b1;
        end
    end

    assign stage_init = stage_init_reg;
    assign done_cnt   = done_reg;
    assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_sqrt_pipe_ctrl.sv
// Self-checking bench for sqrt_pipe_ctrl: directed table, corner sequences, random run vs model.
module tb_sqrt_pipe_ctrl;

    localparam int S = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic        in_ready, out_valid, busy;
    logic [3:0]  stage_en, stage_init;
    logic [2:0]  occupancy;
    logic [15:0] done_cnt;
    logic        in_ready4, out_valid4, busy4;
    logic [3:0]  stage_en4, stage_init4;
    logic [2:0]  occupancy4;
    logic [3:0]  done_cnt4;

    int tests = 0;
    int fails = 0;

    sqrt_pipe_ctrl #(.STAGES(S), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .flush(flush),
        .stage_en(stage_en), .stage_init(stage_init), .occupancy(occupancy),
        .busy(busy), .done_cnt(done_cnt)
    );

    sqrt_pipe_ctrl #(.STAGES(S), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .out_valid(out_valid4), .out_ready(out_ready), .flush(flush),
        .stage_en(stage_en4), .stage_init(stage_init4), .occupancy(occupancy4),
        .busy(busy4), .done_cnt(done_cnt4)
    );

    always #5 clock = ~clock;

    // Reference model: token slots, remaining init cycles (2 = init pulse, 1 = quiet), result count.
    logic [S-1:0] m_valid;
    int           init_m;
    int           done_m;
    logic         m_adv, m_ir, m_ov, m_busy;
    logic [S-1:0] m_en, m_init;
    int           m_occ;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = '0;
        init_m  = 2;
        done_m  = 0;
    endtask

    task automatic model_eval();
        m_occ = 0;
        for (int i = 0; i < S; i++) m_occ += int'(m_valid[i]);
        m_adv  = !m_valid[S-1] || out_ready;
        m_ir   = m_adv && (init_m == 0) && !flush;
        m_ov   = m_valid[S-1] && (init_m == 0);
        m_busy = (init_m != 0) || (m_occ != 0);
        m_init = (init_m == 2) ? '1 : '0;
        m_en[0] = in_valid && m_ir;
        for (int i = 1; i < S; i++) m_en[i] = m_adv && m_valid[i-1];
    endtask

    task automatic model_edge();
        if (m_ov && out_ready) done_m++;
        if (init_m != 0) begin
            init_m--;
        end else if (flush) begin
            m_valid = '0;
            init_m  = 2;
        end else if (m_adv) begin
            m_valid = {m_valid[S-2:0], in_valid && m_ir};
        end
    endtask

    task automatic cycle(input logic iv, input logic ordy, input logic fl);
        @(negedge clock);
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        #1;
        model_eval();
        chk("in_ready",   in_ready,   m_ir);
        chk("out_valid",  out_valid,  m_ov);
        chk("stage_en",   stage_en,   m_en);
        chk("occupancy",  occupancy,  m_occ);
        chk("busy",       busy,       m_busy);
        chk("stage_init", stage_init, m_init);
        chk("done_cnt",   done_cnt,   done_m & 32'hFFFF);
        chk("done_cnt4",  done_cnt4,  done_m & 32'hF);
        $display("[TB] cyc iv=%0b ordy=%0b fl=%0b ir=%0b ov=%0b occ=%0d done=%0d",
                 iv, ordy, fl, in_ready, out_valid, occupancy, done_cnt);
        @(posedge clock);
        model_edge();
    endtask

    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("rst_in_ready",   in_ready,   0);
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_occupancy",  occupancy,  0);
        chk("rst_stage_en",   stage_en,   0);
        chk("rst_stage_init", stage_init, 4'hF);
        chk("rst_busy",       busy,       1);
        chk("rst_done_cnt",   done_cnt,   0);
        chk("rst_done_cnt4",  done_cnt4,  0);
        $display("[TB] reset asserted: ir=%0b ov=%0b occ=%0d init=%h done=%0d",
                 in_ready, out_valid, occupancy, stage_init, done_cnt);
        model_reset();
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
    endtask

    typedef struct {
        logic        iv, ordy, fl;
        logic        ir, ov;
        logic [2:0]  occ;
        logic [3:0]  en, init;
        logic        bsy;
        logic [15:0] done;
    } vec_t;

    vec_t tbl [15];
    int   d0;
    int   guard;

    initial begin
        // Reset release, then 8 back-to-back operands with the consumer always ready.
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 4'hF, 1'b1, 16'd0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 4'h0, 1'b1, 16'd0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0001, 4'h0, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 4'b0011, 4'h0, 1'b1, 16'd0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd2, 4'b0111, 4'h0, 1'b1, 16'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 4'b1111, 4'h0, 1'b1, 16'd0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 4'b1111, 4'h0, 1'b1, 16'd0};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 4'b1111, 4'h0, 1'b1, 16'd1};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 4'b1111, 4'h0, 1'b1, 16'd2};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 4'b1111, 4'h0, 1'b1, 16'd3};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 4'b1110, 4'h0, 1'b1, 16'd4};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 4'b1100, 4'h0, 1'b1, 16'd5};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 4'b1000, 4'h0, 1'b1, 16'd6};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 4'b0000, 4'h0, 1'b1, 16'd7};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0000, 4'h0, 1'b0, 16'd8};

        do_reset();

        for (int r = 0; r < 15; r++) begin
            @(negedge clock);
            in_valid  = tbl[r].iv;
            out_ready = tbl[r].ordy;
            flush     = tbl[r].fl;
            #1;
            model_eval();
            chk($sformatf("t%0d_in_ready", r),   in_ready,   tbl[r].ir);
            chk($sformatf("t%0d_out_valid", r),  out_valid,  tbl[r].ov);
            chk($sformatf("t%0d_occupancy", r),  occupancy,  tbl[r].occ);
            chk($sformatf("t%0d_stage_en", r),   stage_en,   tbl[r].en);
            chk($sformatf("t%0d_stage_init", r), stage_init, tbl[r].init);
            chk($sformatf("t%0d_busy", r),       busy,       tbl[r].bsy);
            chk($sformatf("t%0d_done_cnt", r),   done_cnt,   tbl[r].done);
            $display("[TB] row %0d ir=%0b ov=%0b occ=%0d en=%b init=%h done=%0d",
                     r, in_ready, out_valid, occupancy, stage_en, stage_init, done_cnt);
            @(posedge clock);
            model_edge();
        end

        // Fill the pipe, then stall the consumer for 5 cycles and drain.
        repeat (4) cycle(1'b1, 1'b1, 1'b0);
        repeat (5) begin
            cycle(1'b1, 1'b0, 1'b0);
            #2;
            chk("stall_occ", occupancy, 4);
            chk("stall_ov",  out_valid, 1);
        end
        d0 = done_m;
        repeat (6) cycle(1'b0, 1'b1, 1'b0);
        #2 chk("drain_count", done_cnt, d0 + 4);

        // Flush with three tokens in flight.
        repeat (3) cycle(1'b1, 1'b1, 1'b0);
        #2 chk("pre_flush_occ", occupancy, 3);
        cycle(1'b0, 1'b1, 1'b1);
        #2;
        chk("flush_occ",  occupancy,  0);
        chk("flush_init", stage_init, 4'hF);
        chk("flush_ir",   in_ready,   0);
        cycle(1'b0, 1'b1, 1'b0);
        #2;
        chk("flush_quiet_init", stage_init, 0);
        chk("flush_quiet_ir",   in_ready,   0);
        cycle(1'b0, 1'b1, 1'b0);
        #2 chk("flush_idle_ir", in_ready, 1);
        repeat (4) cycle(1'b0, 1'b1, 1'b0);

        // Flush coinciding with an output transfer and a presented operand.
        repeat (4) cycle(1'b1, 1'b1, 1'b0);
        d0 = done_m;
        cycle(1'b1, 1'b1, 1'b1);
        #2;
        chk("fx_done", done_cnt, d0 + 1);
        chk("fx_occ",  occupancy, 0);
        repeat (3) cycle(1'b1, 1'b1, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0);
        end

        // Small counter wrap: 17 results after a fresh reset.
        do_reset();
        guard = 0;
        while (done_m < 17 && guard < 60) begin
            cycle(1'b1, 1'b1, 1'b0);
            guard++;
        end
        chk("wrap_budget", guard < 60, 1);
        #2;
        chk("wrap_cnt4",  done_cnt4, 1);
        chk("wrap_cnt16", done_cnt,  17);
        repeat (2) cycle(1'b1, 1'b1, 1'b0);

        // Asynchronous reset with the pipe busy.
        do_reset();
        repeat (3) cycle(1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
